pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined adder/subtractor for the ALU datapath, generalising the 8-bit ripple adder.
//   The carry chain is split into STAGES equal chunks, one chunk per register stage.
//   Each stage has valid/ready handshakes on both sides and collapses bubbles.
//   Produces sum plus carry, overflow, zero and negative flags for the ALU flag register.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be a multiple of STAGES (elaboration error otherwise)
//   STAGES   4  pipeline stages, 1..WIDTH; chunk width CW = WIDTH/STAGES
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin; 1: a-b-cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      raw carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   ovf        out  1      signed two's-complement overflow
//   zero       out  1      sum == 0
//   neg        out  1      sum[WIDTH-1]
// BEHAVIOUR
//   - Operand mapping at input: B' = b ^ {WIDTH{sub}}, C0 = cin ^ sub; the result is a + B' + C0.
//   - Stage k (0..STAGES-1) computes bits [k*CW +: CW] from the registered carry of stage k-1.
//     Upper operand bits are carried forward unchanged; lower sum bits are skewed forward.
//   - Latency: exactly STAGES cycles from an accepted input to out_valid, with no stall.
//   - Throughput: one beat per cycle while out_ready=1.
//   - Handshake:
//       - Transfer occurs when valid && ready.
//       - Once out_valid=1, sum/flags/out_valid hold stable until out_ready=1.
//       - Stage k loads if it is empty or stage k+1 is loading (last stage: out_ready).
//       - in_ready = stage-0 load condition; it may depend combinationally on out_ready.
//       - Bubbles between beats are squeezed out while the output is stalled.
//       - A full pipeline holds exactly STAGES beats; beats are never dropped or duplicated.
//   - Flags are computed in the last stage:
//       - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//       - zero = ~|sum; neg = sum[WIDTH-1].
//   - Order: results leave in the same order as the inputs were accepted.
//   - Reset (rst_n=0 at a clock edge):
//       - All stage valids clear; out_valid=0; sum=0; cout=ovf=zero=neg=0.
//       - in_ready=0 while rst_n=0; it is 1 in the first cycle after release.
//       - Reset mid-operation discards all in-flight beats; none appear on the output.
//   - in_valid=0: datapath registers may hold stale data, but out_valid stays 0 for bubbles.
//   - Simultaneous accept at input and output in a full pipeline is legal and keeps occupancy constant.
//   - STAGES=1: a single registered ripple adder with latency 1; the handshake rules are unchanged.
// TESTING (defaults WIDTH=32, STAGES=4, out_ready=1 unless stated)
//   1. a=FFFFFFFF b=00000001 cin=0 sub=0 -> 4 cycles later sum=00000000 cout=1 zero=1 ovf=0 neg=0.
//   2. a=7FFFFFFF b=00000001 sub=0 -> sum=80000000 ovf=1 neg=1 cout=0;
//      a=00000005 b=00000007 sub=1 cin=0 -> sum=FFFFFFFE cout=0 neg=1 ovf=0.
//   3. 100 back-to-back random beats (in_valid=1 constantly) -> 100 results in order, matching a
//      reference model bit-exactly, one per cycle, first one at cycle 4.
//   4. out_ready=0 for 10 cycles while feeding -> exactly 4 beats accepted, then in_ready=0;
//      the output holds stable; after out_ready=1 all beats drain in order with no loss.
//   5. Sparse input (1 beat every 3 cycles) with out_ready toggling -> no duplicated, dropped or
//      reordered results; out_valid=0 during bubbles.
//   6. rst_n=0 for 1 cycle with 3 beats in flight -> out_valid=0 and all outputs 0 next cycle;
//      no flushed beat ever appears; a new beat after reset completes with 4-cycle latency.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor. The carry chain is cut into STAGES equal chunks, one per register stage,
// with per-stage valid/ready flow control that squeezes out bubbles while the output is stalled.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned CW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] load_c;
  logic              all_full;

  // A stage loads unless it and every stage after it are full with the output stalled.
  always_comb begin
    load_c   = '0;
    all_full = ~out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      all_full  = all_full & vld_q[k];
      load_c[k] = ~all_full;
    end
  end

  assign vld_d     = (load_c & STAGES'({vld_q, in_valid})) | (~load_c & vld_q);
  assign in_ready  = rst_n & load_c[0];
  assign out_valid = vld_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed shrink by CW per stage; completed sum bits grow by CW.
    localparam int unsigned RW = WIDTH - k * CW;

    logic [RW-1:0]         src_a;
    logic [RW-1:0]         src_b;
    logic                  src_c;
    logic                  src_v;
    logic [CW:0]           chunk;
    logic [(k+1)*CW-1:0]   s_d;
    logic                  take;

    assign chunk = {1'b0, src_a[CW-1:0]} + {1'b0, src_b[CW-1:0]} + {{CW{1'b0}}, src_c};
    assign take  = load_c[k] & src_v;

    if (k == 0) begin : g_first
      assign src_a = a;
      assign src_b = b ^ {WIDTH{sub}};
      assign src_c = cin ^ sub;
      assign src_v = in_valid;
      assign s_d   = chunk[CW-1:0];
    end else begin : g_next
      assign src_a = g_stage[k-1].g_reg.a_q;
      assign src_b = g_stage[k-1].g_reg.b_q;
      assign src_c = g_stage[k-1].g_reg.c_q;
      assign src_v = vld_q[k-1];
      assign s_d   = {chunk[CW-1:0], g_stage[k-1].g_reg.s_q};
    end

    if (k < STAGES - 1) begin : g_reg
      logic [RW-CW-1:0]    a_q;
      logic [RW-CW-1:0]    b_q;
      logic                c_q;
      logic [(k+1)*CW-1:0] s_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          s_q <= '0;
        end else if (take) begin
          a_q <= src_a[RW-1:CW];
          b_q <= src_b[RW-1:CW];
          c_q <= chunk[CW];
          s_q <= s_d;
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum  <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
          neg  <= 1'b0;
        end else if (take) begin
          sum  <= s_d;
          cout <= chunk[CW];
          ovf  <= src_a[CW-1] ^ src_b[CW-1] ^ chunk[CW-1] ^ chunk[CW];
          zero <= ~|s_d;
          neg  <= s_d[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4): directed corner beats plus
// random streams scored against an arithmetic reference model.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int          n_vec;
  int          n_err;
  int          n_out;
  int          n_acc;
  logic [35:0] exp_q[$];
  bit          hold_in;
  bit          have_prev;
  logic [36:0] prev;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    longint ua, ub, r, sa, sb, sr;
    logic   c, ov;
    logic [31:0] res;
    ua = longint'(x);
    ub = longint'(y);
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    if (!s) begin
      r  = ua + ub + longint'(ci);
      sr = sa + sb + longint'(ci);
      c  = (r >= 64'sd4294967296);
    end else begin
      r  = ua - ub - longint'(ci);
      sr = sa - sb - longint'(ci);
      c  = (ua >= ub + longint'(ci));
    end
    res = r[31:0];
    ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {res, c, ov, (res == 32'h0), res[31]};
  endfunction

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: accepted beats queued in order; results popped and compared; stalled output must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev) check("hold", {out_valid, sum, cout, ovf, zero, neg} >> 1 == prev >> 1 ?
                           36'(1) : 36'(0), 36'(1));
      have_prev = out_valid && !out_ready;
      prev      = {out_valid, sum, cout, ovf, zero, neg};
      if (out_valid && out_ready) begin
        check("spurious", 36'(exp_q.size() != 0), 36'(1));
        if (exp_q.size() != 0) begin
          check("result", {sum, cout, ovf, zero, neg}, exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
    end
  end

  // One cycle of stimulus; a beat not yet accepted keeps its data.
  task automatic step(input bit v, input bit rdy);
    bit took;
    if (v && !hold_in) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom);
      sub = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = sub ? a : ~a;
    end
    in_valid  = v;
    out_ready = rdy;
    @(negedge clk);
    took = in_valid && in_ready;
    @(posedge clk); #1;
    hold_in = v && !took;
  endtask

  task automatic single(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s,
                        input logic [35:0] expv, input string tag);
    int lat;
    a = x; b = y; cin = ci; sub = s;
    in_valid = 1'b1; out_ready = 1'b1; hold_in = 1'b0;
    @(negedge clk);
    check({tag, "_rdy"}, 36'(in_ready), 36'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 36'(lat), 36'(4));
    check({tag, "_res"}, {sum, cout, ovf, zero, neg}, expv);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc0, out0;
    n_vec = 0; n_err = 0; n_out = 0; n_acc = 0;
    hold_in = 1'b0; have_prev = 1'b0; prev = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {sum, cout, ovf, zero, neg}, 36'(0));
    check("rst_oval", 36'(out_valid), 36'(0));
    check("rst_irdy", 36'(in_ready), 36'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_irdy", 36'(in_ready), 36'(1));
    @(posedge clk); #1;

    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}, "t1");
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}, "t2a");
    single(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}, "t2b");

    // Back-to-back stream: one result per cycle.
    acc0 = n_acc; out0 = n_out;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    check("t3_acc", 36'(n_acc - acc0), 36'(100));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk); #1;
    check("t3_out99", 36'(n_out - out0), 36'(99));
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("t3_out100", 36'(n_out - out0), 36'(100));
    @(posedge clk); #1;

    // Output stalled: pipeline fills to exactly STAGES beats, then drains in order.
    acc0 = n_acc; out0 = n_out;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("t4_acc", 36'(n_acc - acc0), 36'(4));
    @(negedge clk); #1;
    check("t4_irdy", 36'(in_ready), 36'(0));
    check("t4_oval", 36'(out_valid), 36'(1));
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check("t4_drain", 36'(n_out - out0), 36'(4));
    check("t4_empty", 36'(exp_q.size()), 36'(0));

    // Sparse input with a toggling consumer.
    acc0 = n_acc; out0 = n_out;
    for (int i = 0; i < 60; i++) step((i % 3) == 0, 1'($urandom));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check("t5_count", 36'(n_out - out0), 36'(n_acc - acc0));
    check("t5_empty", 36'(exp_q.size()), 36'(0));

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    in_valid = 1'b0; rst_n = 1'b0; hold_in = 1'b0;
    @(negedge clk); #1;
    check("t6_irdy0", 36'(in_ready), 36'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("t6_flags", {sum, cout, ovf, zero, neg}, 36'(0));
    check("t6_oval", 36'(out_valid), 36'(0));
    check("t6_irdy1", 36'(in_ready), 36'(1));
    @(posedge clk); #1;
    out0 = n_out;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("t6_noflush", 36'(n_out - out0), 36'(0));
    single(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1), "t6_new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
